// File: rtl/never8_arith_pkg.sv
// Shared arithmetic definitions for the serial adder: FSM state encoding and step sizing.
package never8_arith_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int calc_nstep(input int width, input int digit);
      return width / digit;
   endfunction

   // One extra code point so the counter can represent NSTEP itself.
   function automatic int calc_cnt_w(input int width, input int digit);
      return $clog2((width / digit) + 1);
   endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit combinational ripple adder; also exposes the carry into its top bit for overflow.
module digit_adder #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] sum,
   output logic             co,
   output logic             c_msb
);

   logic [DIGIT:0] c;

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = ci;
      for (int i = 0; i < DIGIT; i++) begin
         sum[i]   = x[i] ^ y[i] ^ c[i];
         c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
      co    = c[DIGIT];
      c_msb = c[DIGIT-1];
   end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle add/subtract, DIGIT bits per clock LSB first; done pulses NSTEP cycles after start.
// No backpressure: start is only accepted in IDLE/DONE and ignored while busy.
module serial_adder
   import never8_arith_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int NSTEP = calc_nstep(WIDTH, DIGIT);
   localparam int CW    = calc_cnt_w(WIDTH, DIGIT);
   localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

   if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
   end

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [DIGIT-1:0]       dsum;
   logic                   dco;
   logic                   dc_msb;
   logic [WIDTH+DIGIT-1:0] s_cat;

   digit_adder #(.DIGIT(DIGIT)) u_digit (
      .x     (a_q[DIGIT-1:0]),
      .y     (b_q[DIGIT-1:0]),
      .ci    (carry_q),
      .sum   (dsum),
      .co    (dco),
      .c_msb (dc_msb)
   );

   // New digit enters at the top so after NSTEP shifts the LSB digit sits at bit 0.
   assign s_cat = {dsum, s_q};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
            if (start) begin
               // Subtract folds into add: a + ~b + !borrow_in.
               a_d     = a;
               b_d     = b ^ {WIDTH{sub}};
               carry_d = cin ^ sub;
               cnt_d   = '0;
               s_d     = '0;
               cout_d  = 1'b0;
               ovf_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            s_d     = s_cat[WIDTH+DIGIT-1:DIGIT];
            carry_d = dco;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               cout_d  = dco;
               ovf_d   = dc_msb ^ dco;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign s    = s_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: one DIGIT=1 and one DIGIT=4 instance against an arithmetic reference model.
module tb_serial_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, sub, cin, start1, start4;
   logic [7:0] a, b;
   logic       busy1, done1, cout1, ovf1;
   logic [7:0] s1;
   logic       busy4, done4, cout4, ovf4;
   logic [7:0] s4;

   int checks = 0;
   int errors = 0;

   serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1)
   );

   serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy4), .done(done4), .s(s4), .cout(cout4), .ovf(ovf4)
   );

   // Returns {ovf, cout, s} from plain 9-bit arithmetic and sign rules.
   function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                        input logic mcin, input logic msub);
      logic [7:0] bb;
      logic [8:0] sum9;
      logic       v;
      bb   = msub ? ~mb : mb;
      sum9 = {1'b0, ma} + {1'b0, bb} + {8'd0, mcin ^ msub};
      v    = (ma[7] == bb[7]) && (sum9[7] != ma[7]);
      return {v, sum9[8], sum9[7:0]};
   endfunction

   // {busy, done, ovf, cout, s}
   function automatic logic [11:0] outs(input int sel);
      if (sel == 1) return {busy1, done1, ovf1, cout1, s1};
      return {busy4, done4, ovf4, cout4, s4};
   endfunction

   task automatic run_op(input int sel, input logic [7:0] ta, input logic [7:0] tb_,
                         input logic tcin, input logic tsub,
                         output int lat, output logic [9:0] res);
      logic [11:0] o;
      a = ta; b = tb_; cin = tcin; sub = tsub;
      if (sel == 1) start1 = 1'b1; else start4 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; start4 = 1'b0;
      lat = 0;
      o = outs(sel);
      while (!o[10] && lat < 20) begin
         @(negedge clk);
         lat++;
         o = outs(sel);
      end
      res = o[9:0];
   endtask

   task automatic test_reset();
      rst = 1'b1; start1 = 1'b1; start4 = 1'b1;
      a = 8'hA5; b = 8'h3C; cin = 1'b1; sub = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (outs(1) !== 12'h000) begin
         errors++; $display("FAIL reset_dut1: got %h expected 000", outs(1));
      end
      checks++;
      if (outs(4) !== 12'h000) begin
         errors++; $display("FAIL reset_dut4: got %h expected 000", outs(4));
      end
      start1 = 1'b0; start4 = 1'b0; rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy1, done1, busy4, done4} !== 4'b0000) begin
         errors++; $display("FAIL reset_idle: got busy/done %b expected 0000", {busy1, done1, busy4, done4});
      end
   endtask

   task automatic test_add_overflow();
      int         lat;
      logic [9:0] res;
      run_op(1, 8'h7F, 8'h01, 1'b0, 1'b0, lat, res);
      checks++;
      if (lat !== 8) begin errors++; $display("FAIL add_ovf_latency: got %0d expected 8", lat); end
      checks++;
      if (res !== {1'b1, 1'b0, 8'h80}) begin
         errors++; $display("FAIL add_ovf_result: got %h expected %h", res, {1'b1, 1'b0, 8'h80});
      end
      @(negedge clk);
      checks++;
      if ({done1, ovf1, cout1, s1} !== {1'b0, 1'b1, 1'b0, 8'h80}) begin
         errors++; $display("FAIL add_ovf_hold: got %h expected %h", {done1, ovf1, cout1, s1}, {1'b0, 1'b1, 1'b0, 8'h80});
      end
   endtask

   task automatic test_subtract();
      int         lat;
      logic [9:0] res;
      run_op(1, 8'h05, 8'h07, 1'b0, 1'b1, lat, res);
      checks++;
      if (res !== {1'b0, 1'b0, 8'hFE} || lat !== 8) begin
         errors++; $display("FAIL sub_neg: got %h lat %0d expected %h lat 8", res, lat, {1'b0, 1'b0, 8'hFE});
      end
      @(negedge clk);
      run_op(1, 8'h80, 8'h01, 1'b0, 1'b1, lat, res);
      checks++;
      if (res !== {1'b1, 1'b1, 8'h7F} || lat !== 8) begin
         errors++; $display("FAIL sub_ovf: got %h lat %0d expected %h lat 8", res, lat, {1'b1, 1'b1, 8'h7F});
      end
      @(negedge clk);
   endtask

   task automatic test_wide_digit();
      int         lat;
      logic [9:0] res;
      run_op(4, 8'hFF, 8'h01, 1'b1, 1'b0, lat, res);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL wide_latency: got %0d expected 2", lat); end
      checks++;
      if (res !== {1'b0, 1'b1, 8'h01}) begin
         errors++; $display("FAIL wide_result: got %h expected %h", res, {1'b0, 1'b1, 8'h01});
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      int         lat, sel, exp_lat;
      logic [7:0] ra, rb;
      logic       rc, rs;
      logic [9:0] res, exp;
      for (int i = 0; i < 24; i++) begin
         sel = (i % 2 == 0) ? 1 : 4;
         exp_lat = (sel == 1) ? 8 : 2;
         ra = 8'($urandom); rb = 8'($urandom);
         rc = 1'($urandom); rs = 1'($urandom);
         exp = model(ra, rb, rc, rs);
         run_op(sel, ra, rb, rc, rs, lat, res);
         checks++;
         if (res !== exp || lat !== exp_lat) begin
            errors++;
            $display("FAIL random_%0d (dut%0d %h %s %h cin %b): got %h lat %0d expected %h lat %0d",
                     i, sel, ra, rs ? "-" : "+", rb, rc, res, lat, exp, exp_lat);
         end
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic test_ignore_start();
      int         lat;
      logic [9:0] exp;
      exp = model(8'h5A, 8'h3C, 1'b1, 1'b0);
      a = 8'h5A; b = 8'h3C; cin = 1'b1; sub = 1'b0; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (done1) break;
         start1 = 1'($urandom_range(0, 1));
         a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      end
      start1 = 1'b0;
      checks++;
      if ({ovf1, cout1, s1} !== exp || lat !== 8) begin
         errors++; $display("FAIL ignore_start: got %h lat %0d expected %h lat 8", {ovf1, cout1, s1}, lat, exp);
      end
      @(negedge clk);
      checks++;
      if ({busy1, done1} !== 2'b00) begin
         errors++; $display("FAIL ignore_start_idle: got busy/done %b expected 00", {busy1, done1});
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      a = 8'h33; b = 8'h44; cin = 1'b0; sub = 1'b0; start1 = 1'b1;
      @(negedge clk);
      lat = 0;
      while (!done1 && lat < 20) begin @(negedge clk); lat++; end
      checks++;
      if (s1 !== 8'h77 || lat !== 8) begin
         errors++; $display("FAIL b2b_first: got %h lat %0d expected 77 lat 8", s1, lat);
      end
      a = 8'h10; b = 8'h20;
      @(negedge clk);
      start1 = 1'b0;
      checks++;
      if ({busy1, done1, s1} !== {1'b1, 1'b0, 8'h00}) begin
         errors++; $display("FAIL b2b_no_gap: got busy/done/s %b %b %h expected 1 0 00", busy1, done1, s1);
      end
      lat = 0;
      while (!done1 && lat < 20) begin @(negedge clk); lat++; end
      checks++;
      if ({ovf1, cout1, s1} !== {1'b0, 1'b0, 8'h30} || lat !== 8) begin
         errors++; $display("FAIL b2b_second: got %h lat %0d expected 030 lat 8", {ovf1, cout1, s1}, lat);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int         lat, pulses;
      logic [9:0] res;
      a = 8'hC3; b = 8'h5A; cin = 1'b0; sub = 1'b1; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy1 !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy1); end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (outs(1) !== 12'h000) begin
         errors++; $display("FAIL mid_reset_outs: got %h expected 000", outs(1));
      end
      rst = 1'b0;
      pulses = 0;
      repeat (12) begin
         @(negedge clk);
         if (done1 || busy1) pulses++;
      end
      checks++;
      if (pulses !== 0) begin errors++; $display("FAIL mid_no_done: got %0d active cycles expected 0", pulses); end
      run_op(1, 8'h12, 8'h34, 1'b0, 1'b0, lat, res);
      checks++;
      if (res !== model(8'h12, 8'h34, 1'b0, 1'b0) || lat !== 8) begin
         errors++; $display("FAIL mid_recover: got %h lat %0d expected %h lat 8", res, lat, model(8'h12, 8'h34, 1'b0, 1'b0));
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_subtract();
      test_wide_digit();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder/subtractor that processes operands DIGIT bits per clock, from least to most significant, with a start/busy/done handshake. It generalises the single-bit full-adder cell to WIDTH-bit add and subtract with carry-in, carry-out and signed overflow. It sits in the datapath as an area-cheap ALU arithmetic unit for the 8-bit core.

## Interface
- WIDTH, 8: operand and result width in bits; must be at least 2.
- DIGIT, 1: bits added per cycle; must divide WIDTH exactly. Elaboration fails otherwise.
- Derived NSTEP = WIDTH/DIGIT: number of compute cycles.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only in IDLE or DONE.
- sub  in  1  0 = a+b+cin; 1 = a-b-cin, computed as a + ~b + !cin.
- a  in  WIDTH  first operand, captured on an accepted start.
- b  in  WIDTH  second operand, captured on an accepted start.
- cin  in  1  carry-in (add) or borrow-in (sub), captured on an accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; s, cout and ovf are valid in that cycle.
- s  out  WIDTH  result.
- cout  out  1  carry-out. For sub this is the not-borrow value (1 means no borrow).
- ovf  out  1  two's-complement overflow, equal to carry into the MSB XOR carry out of the MSB.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - start=1 latches a, b^{WIDTH{sub}} and carry = cin^sub.
  - It clears step count and the s shift register, then goes to RUN.
  - start=0 stays in IDLE.
- **RUN**
  - Each cycle adds the low DIGIT bits of the operand registers plus carry.
  - The sum digit shifts into s from the top; the operand registers shift right by DIGIT; the carry register updates; step count increments.
  - In the step where count == NSTEP-1:
    - cout takes the final carry-out.
    - ovf takes the carry into bit DIGIT-1 of that digit XOR its carry-out.
    - The state goes to DONE.
  - start is ignored in RUN; the operation is neither aborted nor queued.
- **DONE**
  - done=1 for exactly this one cycle.
  - start=1 is accepted exactly as in IDLE (back-to-back) and goes to RUN; otherwise the state goes to IDLE.
- s, cout and ovf hold their last values from DONE until the next accepted start. On that start they clear to 0.
- Intermediate s values are visible during RUN but carry no meaning; consumers qualify on done.
- **Reset**
  - rst=1 forces IDLE.
  - busy, done, s, cout and ovf all become 0; operand, carry and count registers clear.
  - Reset takes priority over start and over any in-flight operation. An aborted operation produces no done.

## Timing
- start sampled at edge E0 gives busy=1 from E0 through E(NSTEP-1).
- done=1 with results valid in the cycle after edge E(NSTEP), i.e. NSTEP cycles after the start edge.
- Examples: WIDTH=8, DIGIT=1 gives done 8 cycles after start; DIGIT=4 gives 2; DIGIT=8 gives 1.
- Throughput is one operation per NSTEP+1 cycles. With back-to-back start in DONE, the next busy rises at the edge that ends done.
- The combinational path per cycle is one DIGIT-bit ripple. No combinational path runs from inputs to outputs.
- All outputs are registered.

## Structure
- Shared package never8_arith_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a function computing NSTEP and the step-counter width $clog2(NSTEP+1).
- One sub-module, digit_adder (parameter DIGIT).
  - Ports: x, y, ci in; sum, co and c_msb (carry into its top bit) out.
  - It is a pure combinational ripple.
- The top level holds the FSM, the operand and result shift registers, and the carry and count registers.

## Test plan
- **Reset:** hold rst=1 for 2 cycles with start=1 → busy=done=s=cout=ovf=0. After release the block stays IDLE until start.
- **Add overflow (WIDTH=8, DIGIT=1):** a=0x7F, b=0x01, cin=0, sub=0 → done exactly 8 cycles after the start edge with s=0x80, cout=0, ovf=1.
- **Subtract (DIGIT=1):**
  - 0x05-0x07, cin=0 → s=0xFE, cout=0, ovf=0.
  - 0x80-0x01 → s=0x7F, cout=1, ovf=1.
- **Wide digit (DIGIT=4):** a=0xFF, b=0x01, cin=1 → done 2 cycles after start with s=0x01, cout=1, ovf=0.
- **Handshake:**
  - start pulses during RUN are ignored; results match the first operands.
  - start held high in DONE launches a second operation (0x10+0x20 → s=0x30) with no idle gap.
- **Reset mid-operation:** rst at the 3rd RUN cycle → all outputs 0 next cycle, no done pulse. A following start computes correctly.
